tcdm_reorder_buffer: RTL
========================

TCDM_REORDER_BUFFER -- requirements
Module: tcdm_reorder_buffer

Interface
REQ-001 SHALL have parameter NumIds, default 8, meaning number of outstanding reorder IDs (power of two, >=2).
REQ-002 SHALL have parameter DataWidth, default 32, meaning response payload width.
REQ-003 SHALL have parameter IdWidth, default $clog2(NumIds), meaning reorder ID width (derived, not overridden).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid_i  input  1  requester wants an ID.
REQ-007 SHALL have port req_ready_o  output  1  ID available this cycle.
REQ-008 SHALL have port req_id_o  output  IdWidth  ID granted on req_valid_i && req_ready_o.
REQ-009 SHALL have port rsp_valid_i  input  1  out-of-order response arrives (no ready; always accepted).
REQ-010 SHALL have port rsp_id_i  input  IdWidth  ID of arriving response.
REQ-011 SHALL have port rsp_data_i  input  DataWidth  response payload.
REQ-012 SHALL have port out_valid_o  output  1  in-order response available.
REQ-013 SHALL have port out_ready_i  input  1  consumer accepts response.
REQ-014 SHALL have port out_data_o  output  DataWidth  in-order payload.
REQ-015 SHALL have port count_o  output  $clog2(NumIds+1)  outstanding-plus-done slot count.
REQ-016 SHALL have port err_o  output  1  one-cycle pulse on illegal response.

Function
REQ-017 Each slot SHALL hold a state FREE, PENDING or DONE plus a DataWidth data register.
REQ-018 Allocation SHALL use head pointer; req_id_o = head; on handshake slot[head] FREE->PENDING, head += 1 mod NumIds.
REQ-019 req_ready_o SHALL equal (count_o != NumIds), independent of req_valid_i and of same-cycle retire.
REQ-020 On rsp_valid_i with slot[rsp_id_i] PENDING, SHALL store rsp_data_i and set DONE at next edge.
REQ-021 On rsp_valid_i with slot[rsp_id_i] FREE or DONE, SHALL drop data, leave state unchanged, pulse err_o next cycle.
REQ-022 out_valid_o SHALL equal (slot[tail] == DONE); out_data_o = data[tail]; both combinational from registers.
REQ-023 On out_valid_o && out_ready_i, slot[tail] DONE->FREE, tail += 1 mod NumIds.
REQ-024 Latency: response accepted in cycle N SHALL give out_valid_o no earlier than cycle N+1; no bypass.
REQ-025 out_valid_o SHALL stay high and out_data_o stable until handshake.
REQ-026 count_o SHALL +1 on alloc only, -1 on retire only, unchanged on both or neither; never exceeds NumIds.
REQ-027 Pointers SHALL wrap from NumIds-1 to 0 without gap.
REQ-028 Alloc, response and retire in the same cycle SHALL all take effect independently (different slots by construction).
REQ-029 Empty (count 0): out_valid_o = 0, req_ready_o = 1; full: req_ready_o = 0 while retire still allowed.

Reset
REQ-030 rst_i high SHALL asynchronously set all slots FREE, head = tail = 0, count_o = 0, err_o = 0, out_valid_o = 0.
REQ-031 Reset mid-operation SHALL discard all pending and done responses; data registers need not be cleared.

Structure
REQ-032 reorder_id_t and NumIds default SHALL live in mempool_pkg, sized from snitch_pkg::ReorderIdWidth.
REQ-033 Slot state enum (FREE/PENDING/DONE) SHALL be a typedef in mempool_pkg.
REQ-034 Block SHALL be flat, no sub-module; pointer/counter logic inline.

Verification (NumIds=4, DataWidth=32)
REQ-035 Allocate 4 IDs -> req_id_o 0,1,2,3; then req_ready_o = 0, count_o = 4.
REQ-036 Responses IDs 2,0,3,1 data 0xC,0xA,0xD,0xB -> out_data_o sequence 0xA,0xB,0xC,0xD; out_valid_o first high cycle after ID0 response.
REQ-037 Full, same-cycle retire ID0 and req_valid_i -> no grant that cycle; grant ID 0 next cycle (wrap), count_o 4.
REQ-038 Response to FREE ID 1 with data 0x55 -> err_o pulse 1 cycle, count_o unchanged, out_valid_o unchanged.
REQ-039 out_ready_i held low 10 cycles with ID0 DONE -> out_valid_o = 1, out_data_o stable throughout.
REQ-040 Assert rst_i mid-stream with 3 pending -> same cycle outputs reset; afterwards req_id_o = 0, count_o = 0.

Source files
------------

// File: rtl/mempool_pkg.sv
// rtl/mempool_pkg.sv - reorder buffer types and defaults
package mempool_pkg;

  // One reorder slot per encodable tag
  localparam int unsigned NumIdsDefault = 2 ** snitch_pkg::ReorderIdWidth;

  typedef logic [snitch_pkg::ReorderIdWidth-1:0] reorder_id_t;

  // Life cycle of a reorder slot: granted, answered, then retired in order
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_DONE    = 2'd2
  } slot_state_e;

endpackage

// File: rtl/snitch_pkg.sv
// rtl/snitch_pkg.sv - core-side constants shared with the memory subsystem
package snitch_pkg;

  // Width of the reorder tag carried with each outstanding TCDM request
  localparam int unsigned ReorderIdWidth = 3;

endpackage

// File: rtl/tcdm_reorder_buffer.sv
// rtl/tcdm_reorder_buffer.sv - hands out IDs in order, accepts responses out of order, returns them in order
module tcdm_reorder_buffer
  import mempool_pkg::*;
#(
  parameter int unsigned NumIds    = NumIdsDefault,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = $clog2(NumIds)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  output logic [IdWidth-1:0]          req_id_o,
  input  logic                        rsp_valid_i,
  input  logic [IdWidth-1:0]          rsp_id_i,
  input  logic [DataWidth-1:0]        rsp_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DataWidth-1:0]        out_data_o,
  output logic [$clog2(NumIds+1)-1:0] count_o,
  output logic                        err_o
);

  localparam int unsigned CntWidth = $clog2(NumIds + 1);

  slot_state_e                state_q [NumIds];
  slot_state_e                state_d [NumIds];
  logic        [DataWidth-1:0] data_q [NumIds];
  logic        [IdWidth-1:0]  head_q, head_d;
  logic        [IdWidth-1:0]  tail_q, tail_d;
  logic        [CntWidth-1:0] count_q, count_d;
  logic                       err_q, err_d;

  logic alloc;
  logic retire;
  logic rsp_ok;

  // Outputs come straight from registers; nothing bypasses from the response port
  assign req_ready_o = (count_q != CntWidth'(NumIds));
  assign req_id_o    = head_q;
  assign out_valid_o = (state_q[tail_q] == SLOT_DONE);
  assign out_data_o  = data_q[tail_q];
  assign count_o     = count_q;
  assign err_o       = err_q;

  assign alloc  = req_valid_i && req_ready_o;
  assign retire = out_valid_o && out_ready_i;
  assign rsp_ok = rsp_valid_i && (state_q[rsp_id_i] == SLOT_PENDING);

  // Next-state for slots, pointers and occupancy; the three events touch disjoint slots
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      state_d[i] = state_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = rsp_valid_i && !rsp_ok;

    if (alloc) begin
      state_d[head_q] = SLOT_PENDING;
      head_d          = head_q + IdWidth'(1);
    end
    if (rsp_ok) begin
      state_d[rsp_id_i] = SLOT_DONE;
    end
    if (retire) begin
      state_d[tail_q] = SLOT_FREE;
      tail_d          = tail_q + IdWidth'(1);
    end

    unique case ({alloc, retire})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset drops every outstanding and completed slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        state_q[i] <= SLOT_FREE;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        state_q[i] <= state_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload storage is only meaningful while its slot is DONE, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (rsp_ok) begin
      data_q[rsp_id_i] <= rsp_data_i;
    end
  end

endmodule
